// File: rtl/io_arb2.sv
// io_arb2 -- two-master round-robin arbiter for a single stb/ack IO slave.
//
// Grants the slave port to one requester at a time. Forwarding from the
// granted master to the slave, and from the slave back to it, is purely
// combinational. A mandatory IDLE cycle separates successive grants. When
// both masters are pending in IDLE, the master that was not served last
// wins.
//
// Optional feature macro: IO_ARB2_TIMEOUT_EN
//   defined   -> watchdog terminates a grant after TO_CYCLES cycles without
//                s_ack. It reports ack+err to the master for one cycle.
//   undefined -> no counter is built and m0_err/m1_err are tied low.
//
// Parameters:
//   ADDR_W     slave address width (default 1)
//   TO_CYCLES  watchdog limit in granted cycles, 2..65535 (default 255)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_stb/we/addr/din        master 0 request, write enable, address, wdata
//   m0_dout/ack/err           master 0 read data, completion, watchdog abort
//   m1_*                      same for master 1
//   s_stb/we/addr/din         request, write enable, address, wdata to slave
//   s_dout/ack                read data and acknowledge from slave

module io_arb2 #(
  parameter int unsigned ADDR_W    = 1,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_din,
  output logic [31:0]       m0_dout,
  output logic              m0_ack,
  output logic              m0_err,

  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_din,
  output logic [31:0]       m1_dout,
  output logic              m1_ack,
  output logic              m1_err,

  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_din,
  input  logic [31:0]       s_dout,
  input  logic              s_ack
);

  if (TO_CYCLES < 2 || TO_CYCLES > 65535) begin : g_bad_to_cycles
    $error("io_arb2: TO_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last;
  logic   w_last_nxt;

  // High in the granted cycle in which the watchdog fires. This is derived
  // only from the counter and the master strobe, never from s_ack, so that
  // suppressing s_stb on this cycle cannot form a loop through a slave
  // whose ack follows its stb.
  logic   w_to_hit;

`ifdef IO_ARB2_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TO_CYCLES);

  logic [15:0] r_to_cnt;
  logic        w_grant_stb;

  always_comb begin
    w_grant_stb = 1'b0;
    case (r_state)
      BUSY0:   w_grant_stb = m0_stb;
      BUSY1:   w_grant_stb = m1_stb;
      default: w_grant_stb = 1'b0;
    endcase
  end

  // Counter is held at zero outside BUSY and on the cycle a grant ends, so
  // every new grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE || w_state_nxt == IDLE) begin
      r_to_cnt <= '0;
    end else if (!s_ack && r_to_cnt != TO_LIM) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // The k-th granted cycle without ack sees a count of k-1. A dropped strobe
  // is treated as an abandon rather than a timeout.
  assign w_to_hit = w_grant_stb && (r_to_cnt == TO_LIM - 16'd1);
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    s_stb       = 1'b0;
    s_we        = 1'b0;
    s_addr      = '0;
    s_din       = '0;
    m0_dout     = '0;
    m0_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_dout     = '0;
    m1_ack      = 1'b0;
    m1_err      = 1'b0;

    case (r_state)
      IDLE: begin
        if (m0_stb && m1_stb) begin
          w_state_nxt = r_last ? BUSY0 : BUSY1;
        end else if (m0_stb) begin
          w_state_nxt = BUSY0;
        end else if (m1_stb) begin
          w_state_nxt = BUSY1;
        end
      end

      BUSY0: begin
        s_stb   = m0_stb & ~w_to_hit;
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_din   = m0_din;
        m0_dout = s_dout;
        m0_ack  = s_ack | w_to_hit;
        m0_err  = w_to_hit & ~s_ack;
        if (s_ack || w_to_hit) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (!m0_stb) begin
          w_state_nxt = IDLE;
        end
      end

      BUSY1: begin
        s_stb   = m1_stb & ~w_to_hit;
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_din   = m1_din;
        m1_dout = s_dout;
        m1_ack  = s_ack | w_to_hit;
        m1_err  = w_to_hit & ~s_ack;
        if (s_ack || w_to_hit) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (!m1_stb) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_io_arb2.sv
// Testbench for io_arb2: echo-style slave model (16-bit registers at
// addresses 0/1, ack follows stb when enabled), directed master traffic,
// and a scoreboard queue of expected acks checked by a negedge monitor.
`timescale 1ns/1ps
module tb_io_arb2;
  localparam int unsigned ADDR_W = 1;
  localparam int unsigned TO_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_stb, m0_we, m1_stb, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_din, m1_din;
  logic [31:0]       m0_dout, m1_dout;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic              s_stb, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_din, s_dout;
  logic              s_ack;
  logic              ack_en;

  io_arb2 #(.ADDR_W(ADDR_W), .TO_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_dout(m0_dout), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_dout(m1_dout), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_din(s_din),
    .s_dout(s_dout), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  // Slave model
  logic [15:0] sreg [2];
  assign s_ack  = s_stb & ack_en;
  assign s_dout = {16'h0000, sreg[s_addr]};
  always @(posedge clk) begin
    if (s_stb && s_ack && s_we) sreg[s_addr] <= s_din[15:0];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int unsigned m;
    logic        err;
    logic        chkd;
    logic [31:0] dout;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  function automatic void push(input int unsigned m, input logic err,
                               input logic chkd, input logic [31:0] dout,
                               input int unsigned c);
    exp_t e;
    e.m = m; e.err = err; e.chkd = chkd; e.dout = dout; e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: every ack pops one expected entry.
  exp_t me;
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      end else begin
        me = sb.pop_front();
        chk("ack_master", {30'd0, m1_ack, m0_ack}, (me.m == 0) ? 32'd1 : 32'd2);
        chk("ack_err", {30'd0, m1_err, m0_err},
            me.err ? ((me.m == 0) ? 32'd1 : 32'd2) : 32'd0);
        chk("ack_cycle", cyc, me.cyc);
        if (me.chkd) chk("ack_dout", (me.m == 0) ? m0_dout : m1_dout, me.dout);
        chk("other_dout", (me.m == 0) ? m1_dout : m0_dout, 32'd0);
      end
    end else if (m0_err || m1_err) begin
      chk("err_without_ack", {30'd0, m1_err, m0_err}, 32'd0);
    end
  end

  task automatic xfer(input int unsigned m, input logic we,
                      input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bit got = 0;
    if (m == 0) begin m0_stb = 1; m0_we = we; m0_addr = a; m0_din = d; end
    else        begin m1_stb = 1; m1_we = we; m1_addr = a; m1_din = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1;
    end
    if (!got) chk("xfer_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (m == 0) m0_stb = 0; else m1_stb = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, m0_ack, m1_ack, m0_err, m1_err, s_stb, s_we}, 32'd0);
    chk({tag, "_data"}, m0_dout | m1_dout | s_din | 32'(s_addr), 32'd0);
  endtask

  int unsigned c;
  int unsigned n_ack, n_err;

  initial begin
    rst = 1; ack_en = 1;
    m0_stb = 0; m0_we = 0; m0_addr = '0; m0_din = '0;
    m1_stb = 0; m1_we = 0; m1_addr = '0; m1_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 0;

    // Single master write then read.
    c = cyc; push(0, 0, 0, 32'h0, c + 1);
    xfer(0, 1'b1, 1'b0, 32'h12345678);
    c = cyc; push(0, 0, 1, 32'h00005678, c + 1);
    xfer(0, 1'b0, 1'b0, 32'h0);

    // Contention right after reset: strict alternation m0, m1, m0, m1.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    c = cyc;
    push(0, 0, 0, 32'h0, c + 1);
    push(1, 0, 0, 32'h0, c + 3);
    push(0, 0, 1, 32'h0000AAAA, c + 5);
    push(1, 0, 1, 32'h0000BBBB, c + 7);
    fork
      begin xfer(0, 1'b1, 1'b0, 32'h0000AAAA); xfer(0, 1'b0, 1'b0, 32'h0); end
      begin xfer(1, 1'b1, 1'b1, 32'h0000BBBB); xfer(1, 1'b0, 1'b1, 32'h0); end
    join

    // Fairness: m1 back-to-back, m0 requests once while m1 is busy.
    c = cyc;
    push(1, 0, 1, 32'h0000BBBB, c + 1);
    push(0, 0, 1, 32'h0000AAAA, c + 3);
    push(1, 0, 1, 32'h0000BBBB, c + 5);
    push(1, 0, 1, 32'h0000BBBB, c + 7);
    fork
      begin repeat (3) xfer(1, 1'b0, 1'b1, 32'h0); end
      begin @(posedge clk); #1; xfer(0, 1'b0, 1'b0, 32'h0); end
    join

    // Abandon: m0 drops stb while granted; last (=1) must be unchanged.
    ack_en = 0;
    m0_stb = 1; m0_we = 0; m0_addr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abandon_busy_stb", {31'd0, s_stb}, 32'd1);
    m0_stb = 0;
    @(negedge clk);
    chk("abandon_idle", {29'd0, s_stb, m0_ack, m1_ack}, 32'd0);
    ack_en = 1;
    @(posedge clk); #1;
    c = cyc;
    push(0, 0, 1, 32'h0000AAAA, c + 1);
    push(1, 0, 1, 32'h0000BBBB, c + 3);
    fork
      xfer(0, 1'b0, 1'b0, 32'h0);
      xfer(1, 1'b0, 1'b1, 32'h0);
    join

    // Make m0 the last served so the reset value of last is observable.
    c = cyc; push(0, 0, 0, 32'h0, c + 1);
    xfer(0, 1'b1, 1'b0, 32'h0000AAAA);

    // Reset mid-transaction, then fresh contention must grant m0 first.
    ack_en = 0;
    c = cyc;
    push(0, 0, 1, 32'h0000AAAA, c + 3);
    push(1, 0, 1, 32'h0000BBBB, c + 5);
    fork
      xfer(0, 1'b0, 1'b0, 32'h0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy_stb", {31'd0, s_stb}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; ack_en = 1;
        @(negedge clk);
        chk_all_zero("rstmid");
      end
      begin repeat (2) @(posedge clk); #1; xfer(1, 1'b0, 1'b1, 32'h0); end
    join

    // Slave never acks.
    ack_en = 0;
    c = cyc;
`ifdef IO_ARB2_TIMEOUT_EN
    push(1, 1, 0, 32'h0, c + TO_CYC);
    fork
      xfer(1, 1'b0, 1'b1, 32'h0);
      begin
        repeat (TO_CYC - 1) @(posedge clk);
        @(negedge clk);
        chk("wd_pre_stb", {31'd0, s_stb}, 32'd1);
        @(negedge clk);
        chk("wd_hit_stb", {31'd0, s_stb}, 32'd0);
      end
    join
    ack_en = 1;
    c = cyc; push(1, 0, 1, 32'h0000BBBB, c + 1);
    xfer(1, 1'b0, 1'b1, 32'h0);
`else
    m1_stb = 1; m1_we = 0; m1_addr = 1'b1;
    n_ack = 0; n_err = 0;
    repeat (100) begin
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack++;
      if (m0_err || m1_err) n_err++;
    end
    chk("noto_acks", n_ack, 32'd0);
    chk("noto_err", n_err, 32'd0);
    chk("noto_grant_held", {31'd0, s_stb}, 32'd1);
    m1_stb = 0;
    @(negedge clk);
    chk("noto_abandon", {31'd0, s_stb}, 32'd0);
    ack_en = 1;
`endif

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
